// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback arbiter and its scoreboard.
// Imported by every file of the writeback slice.
package wb_pkg;

    localparam int XLEN                    = 32;
    localparam int REG_ADDR_W              = 5;
    localparam int NUM_REGS                = 1 << REG_ADDR_W;
    localparam int FORCE_THRESHOLD_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic int cnt_width(input int thresh);
        return (thresh < 1) ? 1 : $clog2(thresh + 1);
    endfunction

    // x0 never maps to a scoreboard bit
    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[rd] = (rd != '0);
        return oh;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for in-flight loads with two decode lookup ports.
// A set and a clear of the same register on one edge leaves it busy.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1_select,
    input  logic [REG_ADDR_W-1:0] rs2_select,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask     = set_valid ? rd_onehot(set_rd) : '0;
        clr_mask     = clr_valid ? rd_onehot(clr_rd) : '0;
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1_select];
    assign rs2_busy = busy[rs2_select];

endmodule

// File: rtl/wb_arbiter.sv
// Single-port register-file writeback arbiter between ALU and LSU results.
// ALU has priority; a buffered load result is forced out after a bounded wait.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FORCE_THRESHOLD = FORCE_THRESHOLD_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_wr_valid,
    input  logic [REG_ADDR_W-1:0] alu_wr_rd,
    input  logic [XLEN-1:0]       alu_wr_data,
    output logic                  alu_wr_ready,
    input  logic                  lsu_issue_valid,
    input  logic [REG_ADDR_W-1:0] lsu_issue_rd,
    input  logic                  lsu_wr_valid,
    input  logic [REG_ADDR_W-1:0] lsu_wr_rd,
    input  logic [XLEN-1:0]       lsu_wr_data,
    output logic                  lsu_wr_ready,
    input  logic [REG_ADDR_W-1:0] rs1_select,
    input  logic [REG_ADDR_W-1:0] rs2_select,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  reg_write_control,
    output logic [REG_ADDR_W-1:0] reg_write_select,
    output logic [XLEN-1:0]       reg_write_data
);

    localparam int               CNT_W     = cnt_width(FORCE_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FORCE_THRESHOLD);

    wb_state_e        state;
    wb_state_e        state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0] wait_inc;
    wb_entry_t        held;
    wb_entry_t        held_next;

    logic alu_fire;
    logic lsu_fire;
    logic buf_write;

    assign alu_wr_ready = (state != ST_FORCE);
    assign lsu_wr_ready = (state == ST_EMPTY);
    assign alu_fire     = alu_wr_valid && alu_wr_ready;
    assign lsu_fire     = lsu_wr_valid && lsu_wr_ready;
    assign wait_inc     = wait_cnt + CNT_W'(1);

    // The buffer drains on any edge where the ALU does not take the port.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        held_next     = held;
        buf_write     = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (lsu_fire) begin
                    state_next     = ST_HELD;
                    wait_cnt_next  = '0;
                    held_next.rd   = lsu_wr_rd;
                    held_next.data = lsu_wr_data;
                end
            end
            ST_HELD: begin
                if (alu_wr_valid) begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc >= CNT_LIMIT) begin
                        state_next = ST_FORCE;
                    end
                end else begin
                    buf_write  = 1'b1;
                    state_next = ST_EMPTY;
                end
            end
            ST_FORCE: begin
                buf_write  = 1'b1;
                state_next = ST_EMPTY;
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            wait_cnt <= '0;
            held     <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            held     <= held_next;
        end
    end

    // ALU and buffer writes never coincide; x0 writes complete silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_control <= 1'b0;
            reg_write_select  <= '0;
            reg_write_data    <= '0;
        end else begin
            reg_write_control <= 1'b0;
            if (alu_fire && (alu_wr_rd != '0)) begin
                reg_write_control <= 1'b1;
                reg_write_select  <= alu_wr_rd;
                reg_write_data    <= alu_wr_data;
            end else if (buf_write && (held.rd != '0)) begin
                reg_write_control <= 1'b1;
                reg_write_select  <= held.rd;
                reg_write_data    <= held.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (lsu_issue_valid),
        .set_rd     (lsu_issue_rd),
        .clr_valid  (buf_write),
        .clr_rd     (held.rd),
        .rs1_select (rs1_select),
        .rs2_select (rs2_select),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter against a queue-based model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_wb_arbiter;

    localparam int TH = 2;

    logic        clk;
    logic        reset;
    logic        alu_wr_valid;
    logic [4:0]  alu_wr_rd;
    logic [31:0] alu_wr_data;
    logic        alu_wr_ready;
    logic        lsu_issue_valid;
    logic [4:0]  lsu_issue_rd;
    logic        lsu_wr_valid;
    logic [4:0]  lsu_wr_rd;
    logic [31:0] lsu_wr_data;
    logic        lsu_wr_ready;
    logic [4:0]  rs1_select;
    logic [4:0]  rs2_select;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        reg_write_control;
    logic [4:0]  reg_write_select;
    logic [31:0] reg_write_data;

    wb_arbiter #(.FORCE_THRESHOLD(TH)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_wr_valid      (alu_wr_valid),
        .alu_wr_rd         (alu_wr_rd),
        .alu_wr_data       (alu_wr_data),
        .alu_wr_ready      (alu_wr_ready),
        .lsu_issue_valid   (lsu_issue_valid),
        .lsu_issue_rd      (lsu_issue_rd),
        .lsu_wr_valid      (lsu_wr_valid),
        .lsu_wr_rd         (lsu_wr_rd),
        .lsu_wr_data       (lsu_wr_data),
        .lsu_wr_ready      (lsu_wr_ready),
        .rs1_select        (rs1_select),
        .rs2_select        (rs2_select),
        .rs1_busy          (rs1_busy),
        .rs2_busy          (rs2_busy),
        .reg_write_control (reg_write_control),
        .reg_write_select  (reg_write_select),
        .reg_write_data    (reg_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        pend[$];
    int          streak;
    bit [31:0]   busy_m;
    logic        e_ctrl;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    int          checks;
    int          errors;

    function automatic bit m_lsu_ready();
        return pend.size() == 0;
    endfunction

    function automatic bit m_alu_ready();
        return !(pend.size() != 0 && streak >= TH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        streak = 0;
        busy_m = '0;
        e_ctrl = 1'b0;
        e_sel  = '0;
        e_data = '0;
    endtask

    // One edge of the arbitration rules, applied to the current inputs.
    task automatic model_update();
        bit   alu_acc;
        bit   lsu_acc;
        bit   drain;
        ent_t head;
        if (!reset) return;
        alu_acc = alu_wr_valid && m_alu_ready();
        lsu_acc = lsu_wr_valid && m_lsu_ready();
        drain   = (pend.size() != 0) && !alu_acc;
        e_ctrl  = 1'b0;
        if (alu_acc && alu_wr_rd != 0) begin
            e_ctrl = 1'b1;
            e_sel  = alu_wr_rd;
            e_data = alu_wr_data;
        end
        if (drain) begin
            head   = pend.pop_front();
            streak = 0;
            if (head.rd != 0) begin
                e_ctrl           = 1'b1;
                e_sel            = head.rd;
                e_data           = head.data;
                busy_m[head.rd]  = 1'b0;
            end
        end else if (alu_acc && pend.size() != 0) begin
            streak++;
        end
        if (lsu_acc) begin
            pend.push_back('{lsu_wr_rd, lsu_wr_data});
            streak = 0;
        end
        if (lsu_issue_valid && lsu_issue_rd != 0)
            busy_m[lsu_issue_rd] = 1'b1;
    endtask

    task automatic check_all();
        chk("alu_ready", alu_wr_ready, m_alu_ready());
        chk("lsu_ready", lsu_wr_ready, m_lsu_ready());
        chk("rs1_busy", rs1_busy, busy_m[rs1_select]);
        chk("rs2_busy", rs2_busy, busy_m[rs2_select]);
        chk("wr_ctrl", reg_write_control, e_ctrl);
        chk("wr_sel", reg_write_select, e_sel);
        chk("wr_data", reg_write_data, e_data);
    endtask

    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_wr_valid    = 1'b0;
        alu_wr_rd       = '0;
        alu_wr_data     = '0;
        lsu_issue_valid = 1'b0;
        lsu_issue_rd    = '0;
        lsu_wr_valid    = 1'b0;
        lsu_wr_rd       = '0;
        lsu_wr_data     = '0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        rs1_select = '0;
        rs2_select = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        step();
        reset = 1'b1;

        // ALU write to x5
        alu_wr_valid = 1'b1;
        alu_wr_rd    = 5'd5;
        alu_wr_data  = 32'h1234_5678;
        step();
        idle_inputs();
        chk("alu_ctrl", reg_write_control, 1'b1);
        chk("alu_sel", reg_write_select, 5'd5);
        chk("alu_data", reg_write_data, 32'h1234_5678);

        // load to x7: busy until its result is written
        lsu_issue_valid = 1'b1;
        lsu_issue_rd    = 5'd7;
        rs1_select      = 5'd7;
        step();
        idle_inputs();
        chk("busy7_set", rs1_busy, 1'b1);
        lsu_wr_valid = 1'b1;
        lsu_wr_rd    = 5'd7;
        lsu_wr_data  = 32'hA5A5_A5A5;
        step();
        idle_inputs();
        chk("lsu_e0_ctrl", reg_write_control, 1'b0);
        chk("busy7_hold", rs1_busy, 1'b1);
        step();
        chk("lsu_e1_ctrl", reg_write_control, 1'b1);
        chk("lsu_e1_data", reg_write_data, 32'hA5A5_A5A5);
        chk("busy7_clr", rs1_busy, 1'b0);

        // ALU streak forces the buffered result out
        lsu_wr_valid = 1'b1;
        lsu_wr_rd    = 5'd9;
        lsu_wr_data  = 32'h0000_0099;
        step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            alu_wr_valid = 1'b1;
            alu_wr_rd    = 5'd10 + 5'(i);
            alu_wr_data  = 32'hC0DE_0000 + i;
            step();
            chk("streak_alu_sel", reg_write_select, 5'd10 + 5'(i));
        end
        #1 chk("force_alu_ready", alu_wr_ready, 1'b0);
        step();
        chk("force_sel", reg_write_select, 5'd9);
        chk("force_ctrl", reg_write_control, 1'b1);
        idle_inputs();
        #1 chk("after_force_ready", alu_wr_ready, 1'b1);

        // x0 write handshakes but never reaches the port
        alu_wr_valid = 1'b1;
        alu_wr_rd    = 5'd0;
        alu_wr_data  = 32'hFFFF_FFFF;
        #1 chk("x0_ready", alu_wr_ready, 1'b1);
        step();
        idle_inputs();
        chk("x0_ctrl", reg_write_control, 1'b0);

        // reissue of x3 on the edge its previous result is written
        lsu_wr_valid = 1'b1;
        lsu_wr_rd    = 5'd3;
        lsu_wr_data  = 32'h0303_0303;
        step();
        idle_inputs();
        lsu_issue_valid = 1'b1;
        lsu_issue_rd    = 5'd3;
        rs2_select      = 5'd3;
        step();
        idle_inputs();
        chk("x3_write", reg_write_select, 5'd3);
        chk("x3_busy", rs2_busy, 1'b1);

        // reset while a load result is held
        lsu_issue_valid = 1'b1;
        lsu_issue_rd    = 5'd12;
        rs1_select      = 5'd12;
        lsu_wr_valid    = 1'b1;
        lsu_wr_rd       = 5'd12;
        lsu_wr_data     = 32'h1212_1212;
        step();
        idle_inputs();
        chk("held_lsu_ready", lsu_wr_ready, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_lsu_ready", lsu_wr_ready, 1'b1);
        chk("rst_busy1", rs1_busy, 1'b0);
        chk("rst_busy2", rs2_busy, 1'b0);
        alu_wr_valid = 1'b1;
        alu_wr_rd    = 5'd6;
        alu_wr_data  = 32'h6666_6666;
        step();
        chk("rst_no_write", reg_write_control, 1'b0);
        reset = 1'b1;
        idle_inputs();
        step();
        chk("release_no_write", reg_write_control, 1'b0);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            alu_wr_valid    = ($urandom_range(0, 99) < 55);
            alu_wr_rd       = 5'($urandom_range(0, 7));
            alu_wr_data     = $urandom;
            lsu_wr_valid    = ($urandom_range(0, 99) < 50);
            lsu_wr_rd       = 5'($urandom_range(0, 7));
            lsu_wr_data     = $urandom;
            lsu_issue_valid = ($urandom_range(0, 99) < 30);
            lsu_issue_rd    = 5'($urandom_range(0, 7));
            rs1_select      = 5'($urandom_range(0, 7));
            rs2_select      = 5'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FORCE_THRESHOLD, default 2, meaning consecutive ALU wins tolerated while an LSU result waits.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 alu_wr_valid / alu_wr_rd / alu_wr_data  input  1/5/32  ALU writeback request.
REQ-005 alu_wr_ready  output  1  ALU request accepted this cycle.
REQ-006 lsu_issue_valid / lsu_issue_rd  input  1/5  load issued; destination becomes busy.
REQ-007 lsu_wr_valid / lsu_wr_rd / lsu_wr_data  input  1/5/32  load-result writeback request.
REQ-008 lsu_wr_ready  output  1  LSU result accepted this cycle.
REQ-009 rs1_select / rs2_select  input  5/5  decode-stage source registers.
REQ-010 rs1_busy / rs2_busy  output  1/1  source has a load in flight.
REQ-011 reg_write_control / reg_write_select / reg_write_data  output  1/5/32  register-file write port, registered.

Function
REQ-012 One register-file write per cycle; write-port outputs driven only from flops, 1-cycle latency from accepting edge.
REQ-013 ALU handshake: accepted at posedge when alu_wr_valid and alu_wr_ready; write port carries it the following cycle.
REQ-014 LSU handshake: accepted into a 1-entry buffer at posedge when lsu_wr_valid and lsu_wr_ready; lsu_wr_ready = (state == EMPTY).
REQ-015 States: EMPTY (buffer empty), HELD (buffer valid), FORCE (buffer valid, ALU blocked).
REQ-016 EMPTY: alu_wr_ready=1; LSU accept -> HELD, wait_cnt=0.
REQ-017 HELD: alu_wr_ready=1; ALU valid -> ALU wins, wait_cnt+1; wait_cnt reaching FORCE_THRESHOLD -> FORCE; ALU idle -> buffer written, -> EMPTY.
REQ-018 FORCE: alu_wr_ready=0; buffer written at next edge -> EMPTY.
REQ-019 Minimum LSU latency: accept edge E0, write port valid after E1; LSU throughput 1 per 2 cycles.
REQ-020 Requests with rd=0: handshake completes, reg_write_control stays 0, scoreboard unchanged.
REQ-021 Scoreboard: 32 busy bits, bit 0 constant 0; set at edge on lsu_issue_valid with rd!=0; cleared at edge where buffer entry is written for that rd.
REQ-022 Same-edge set and clear of one rd: set wins.
REQ-023 rsN_busy = busy[rsN_select], combinational, reflects state before the current edge.
REQ-024 ALU write to a busy rd: performed; busy bit unchanged.
REQ-025 Idle cycles: reg_write_control=0; select/data hold previous values.

Reset
REQ-026 Reset asserted (low), asynchronously: state=EMPTY, wait_cnt=0, buffer invalid, busy=0, reg_write_control=0, reg_write_select=0, reg_write_data=0.
REQ-027 Reset mid-operation discards buffered LSU result and all busy bits; no write issued during or on release.
REQ-028 Outputs after reset: alu_wr_ready=1, lsu_wr_ready=1, rs1_busy=rs2_busy=0.

Structure
REQ-029 Package wb_pkg holds state enum, XLEN=32, REG_ADDR_W=5, FORCE_THRESHOLD default.
REQ-030 Sub-module wb_scoreboard holds busy vector, set/clear logic and both lookup ports; arbitration FSM stays in wb_arbiter.

Verification
REQ-031 After reset, ALU rd=5 data=0x1234_5678 -> next cycle write port 1/5/0x12345678.
REQ-032 Issue load rd=7, rs1_select=7 -> rs1_busy=1; LSU rd=7 data=0xA5A5A5A5 with ALU idle -> write two edges later, rs1_busy=0 after that edge.
REQ-033 LSU accept then ALU valid every cycle -> two ALU writes, alu_wr_ready=0 one cycle, LSU write, alu_wr_ready=1.
REQ-034 ALU rd=0 data=0xFFFFFFFF -> alu_wr_ready=1, reg_write_control stays 0.
REQ-035 Issue rd=3 same edge as buffer write of rd=3 -> busy[3]=1 afterward.
REQ-036 Reset asserted while HELD -> immediate EMPTY, no write, lsu_wr_ready=1, busy all 0.
